padd_sat_seq: RTL and testbench

//  Multi-beat sequencer for the packed saturating add/sub datapath of the ALU/shifter.

---
 rtl/padd_sat_seq.sv | 147 ++++++++++++++
 tb/tb_padd_sat_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/padd_sat_seq.sv
// Multi-beat sequencer feeding one DW-bit lane per cycle to the packed saturating ALU.
// Optional sticky saturation flag is built only when SATU_STICKY_EN is defined.
module padd_sat_seq #(
  parameter int DW     = 16,
  parameter int NBEATS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [DW*NBEATS-1:0] req_a,
  input  logic [DW*NBEATS-1:0] req_b,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic                 alu_s1,
  output logic                 alu_sat,
  output logic                 alu_sub,
  input  logic [DW-1:0]        alu_res,
  input  logic [1:0]           alu_v,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW*NBEATS-1:0] rsp_data,
  output logic                 rsp_sat,
  output logic                 sticky_sat,
  input  logic                 sticky_clr
);

  localparam int W  = DW * NBEATS;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] beat;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          accept;
  logic          last_beat;
  logic          lane_sat;

  assign accept    = req_valid && (state == S_IDLE);
  assign last_beat = (beat == BW'(NBEATS - 1));

  // Word mode only reports the word overflow flag; wrap-around ADD never flags.
  assign lane_sat = alu_sat && (alu_s1 ? (alu_v[1] || alu_v[0]) : alu_v[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_s1    = 1'b0;
    alu_sat   = 1'b0;
    alu_sub   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a   = a_q[beat*DW +: DW];
        alu_b   = b_q[beat*DW +: DW];
        alu_s1  = op_q[1];
        alu_sat = (op_q != 2'b00);
        alu_sub = (op_q == 2'b11);
        if (last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Accept clears the previous response so it can never leak into the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat     <= '0;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      rsp_data <= '0;
      rsp_sat  <= 1'b0;
    end else if (accept) begin
      beat     <= '0;
      op_q     <= req_op;
      a_q      <= req_a;
      b_q      <= req_b;
      rsp_data <= '0;
      rsp_sat  <= 1'b0;
    end else if (state == S_EXEC) begin
      rsp_data[beat*DW +: DW] <= alu_res;
      rsp_sat                 <= rsp_sat || lane_sat;
      if (!last_beat) begin
        beat <= beat + 1'b1;
      end
    end
  end

`ifdef SATU_STICKY_EN
  logic sticky_q;

  // A new saturation event outranks a simultaneous clear so it is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (rsp_valid && rsp_ready && rsp_sat) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_sat = sticky_q;
`else
  logic unused_sticky_clr;

  assign unused_sticky_clr = sticky_clr;
  assign sticky_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_padd_sat_seq.sv
// Directed self-checking bench for padd_sat_seq (DW=16, NBEATS=2) with a behavioural
// byte/word signed saturating ALU model; sticky checks follow SATU_STICKY_EN.
module tb_padd_sat_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_s1;
  logic        alu_sat;
  logic        alu_sub;
  logic [15:0] alu_res;
  logic [1:0]  alu_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_sat;
  logic        sticky_sat;
  logic        sticky_clr;

  int testCount = 0;
  int failCount = 0;

  padd_sat_seq #(.DW(16), .NBEATS(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_s1(alu_s1),
    .alu_sat(alu_sat),
    .alu_sub(alu_sub),
    .alu_res(alu_res),
    .alu_v(alu_v),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_sat(rsp_sat),
    .sticky_sat(sticky_sat),
    .sticky_clr(sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {V_h, V_l, result}; flags are raised even when sat is off.
  function automatic logic [17:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic s1, input logic sat, input logic sub);
    logic [16:0] w;
    logic [8:0]  h;
    logic [8:0]  l;
    logic [15:0] r;
    logic [1:0]  v;
    if (s1) begin
      h = sub ? ({a[15], a[15:8]} - {b[15], b[15:8]}) : ({a[15], a[15:8]} + {b[15], b[15:8]});
      l = sub ? ({a[7], a[7:0]} - {b[7], b[7:0]}) : ({a[7], a[7:0]} + {b[7], b[7:0]});
      v[1] = h[8] ^ h[7];
      v[0] = l[8] ^ l[7];
      r[15:8] = (sat && v[1]) ? (h[8] ? 8'h80 : 8'h7F) : h[7:0];
      r[7:0]  = (sat && v[0]) ? (l[8] ? 8'h80 : 8'h7F) : l[7:0];
    end else begin
      w = sub ? ({a[15], a} - {b[15], b}) : ({a[15], a} + {b[15], b});
      v[1] = w[16] ^ w[15];
      v[0] = 1'b0;
      r = (sat && v[1]) ? (w[16] ? 16'h8000 : 16'h7FFF) : w[15:0];
    end
    return {v, r};
  endfunction

  assign {alu_v, alu_res} = aluModel(alu_a, alu_b, alu_s1, alu_sat, alu_sub);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and waits (bounded) for rsp_valid; leaves us 1ns after a rising edge.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] expMode,
                               output int lat);
    checkOutput({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput({tag, "_mode"}, {61'd0, alu_s1, alu_sat, alu_sub}, {61'd0, expMode});
    checkOutput({tag, "_alu_a0"}, {48'd0, alu_a}, {48'd0, a[15:0]});
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic completeRsp(input logic clr);
    rsp_ready  = 1'b1;
    sticky_clr = clr;
    @(posedge clk);
    #1;
    rsp_ready  = 1'b0;
    sticky_clr = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] expMode,
                       input logic [31:0] expData, input logic expSat, input logic clr);
    int lat;
    applyStimulus(tag, op, a, b, expMode, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd2);
    checkOutput({tag, "_data"}, {32'd0, rsp_data}, {32'd0, expData});
    checkOutput({tag, "_sat"}, {63'd0, rsp_sat}, {63'd0, expSat});
    completeRsp(clr);
  endtask

  task automatic pulseClear();
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    sticky_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_ctrl", {60'd0, req_ready, rsp_valid, rsp_sat, sticky_sat}, 64'h8);
    checkOutput("reset_data", {32'd0, rsp_data}, 64'd0);
    checkOutput("reset_alu", {29'd0, alu_a, alu_b, alu_s1, alu_sat, alu_sub}, 64'd0);

    runOp("addsb", 2'b10, 32'h0000_7F10, 32'h0000_0110, 3'b110, 32'h0000_7F20, 1'b1, 1'b0);
    checkOutput("idle_alu", {29'd0, alu_a, alu_b, alu_s1, alu_sat, alu_sub}, 64'd0);
    runOp("add_nocarry", 2'b00, 32'h0001_FFFF, 32'h0000_0001, 3'b000, 32'h0001_0000, 1'b0, 1'b0);
    runOp("add_wrap", 2'b00, 32'h0000_7FFF, 32'h0000_0001, 3'b000, 32'h0000_8000, 1'b0, 1'b0);
    runOp("addsw", 2'b01, 32'h8000_7FFF, 32'hFFFF_0001, 3'b010, 32'h8000_7FFF, 1'b1, 1'b0);
    runOp("subsb", 2'b11, 32'h0000_0080, 32'h0000_0001, 3'b111, 32'h0000_0080, 1'b1, 1'b0);
    runOp("addsb_nosat", 2'b10, 32'h0102_0304, 32'h0101_0101, 3'b110, 32'h0203_0405, 1'b0, 1'b0);
    runOp("subsb_lo", 2'b11, 32'h7F00_0010, 32'hFF00_0020, 3'b111, 32'h7F00_00F0, 1'b1, 1'b0);

    // Response held off for five cycles while a competing request is presented.
    applyStimulus("stall", 2'b00, 32'h1234_5678, 32'h1111_1111, 3'b000, lat);
    checkOutput("stall_latency", 64'(lat), 64'd2);
    req_op    = 2'b10;
    req_a     = 32'h7F7F_7F7F;
    req_b     = 32'h7F7F_7F7F;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_hold", {30'd0, rsp_valid, req_ready, rsp_data}, {30'd2, 32'h2345_6789});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("stall_back_idle", {62'd0, req_ready, rsp_valid}, 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_no_accept", {62'd0, rsp_valid, alu_sat}, 64'd0);
    end

    // Reset during the first execute beat aborts the operation.
    req_op    = 2'b01;
    req_a     = 32'h7FFF_7FFF;
    req_b     = 32'h0001_0001;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("abort_in_exec", {62'd0, alu_sat, req_ready}, 64'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_ctrl", {61'd0, req_ready, rsp_valid, rsp_sat}, 64'd4);
    checkOutput("abort_alu", {29'd0, alu_a, alu_b, alu_s1, alu_sat, alu_sub}, 64'd0);
    checkOutput("abort_data", {32'd0, rsp_data}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end

`ifdef SATU_STICKY_EN
    checkOutput("sticky_after_reset", {63'd0, sticky_sat}, 64'd0);
    runOp("sticky_nosat", 2'b00, 32'h0000_7FFF, 32'h0000_0001, 3'b000, 32'h0000_8000, 1'b0, 1'b0);
    checkOutput("sticky_not_set", {63'd0, sticky_sat}, 64'd0);
    runOp("sticky_set", 2'b10, 32'h0000_7F10, 32'h0000_0110, 3'b110, 32'h0000_7F20, 1'b1, 1'b0);
    checkOutput("sticky_set", {63'd0, sticky_sat}, 64'd1);
    pulseClear();
    checkOutput("sticky_clear", {63'd0, sticky_sat}, 64'd0);
    runOp("sticky_set2", 2'b01, 32'h8000_7FFF, 32'hFFFF_0001, 3'b010, 32'h8000_7FFF, 1'b1, 1'b0);
    checkOutput("sticky_set2", {63'd0, sticky_sat}, 64'd1);
    runOp("sticky_race", 2'b11, 32'h0000_0080, 32'h0000_0001, 3'b111, 32'h0000_0080, 1'b1, 1'b1);
    checkOutput("sticky_set_wins", {63'd0, sticky_sat}, 64'd1);
    pulseClear();
    checkOutput("sticky_clear2", {63'd0, sticky_sat}, 64'd0);
`else
    runOp("nosticky_op", 2'b10, 32'h0000_7F10, 32'h0000_0110, 3'b110, 32'h0000_7F20, 1'b1, 1'b0);
    checkOutput("sticky_tied_low", {63'd0, sticky_sat}, 64'd0);
    pulseClear();
    checkOutput("sticky_clr_ignored", {63'd0, sticky_sat}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
